// File: rtl/usb_uart_cmd.sv
// usb_uart_cmd: ASCII command/register bridge for the USB serial link.
//
// The host sends short hex commands over the rx byte stream:
//   r/R + 2 hex digits           register read,  reply "HL\n" (uppercase hex)
//   w/W + 4 hex digits (aa dd)   register write, reply "k\n"
// CR, LF and space are ignored between commands. Any other byte, or a bad
// digit inside a command, gets the reply "?\n" and no bus access. A partial
// command that sees no byte for TIMEOUT_CYCLES cycles is dropped silently.
//
// Optional build macro USB_UART_CMD_ECHO_EN: every byte accepted while
// parsing is echoed on tx before it is acted on.
//
// Parameters:
//   READ_LATENCY    cycles from reg_re to valid reg_rdata (1..4)
//   TIMEOUT_CYCLES  idle cycles inside a partial command before abort (>= 2)
//
// Ports:
//   clk_48mhz, reset            clock, synchronous active-high reset
//   rx_data/rx_valid/rx_ready   host-to-device byte stream (uart_out side)
//   tx_data/tx_valid/tx_ready   device-to-host byte stream (uart_in side)
//   reg_addr, reg_wdata         register bus address and write data
//   reg_we, reg_re              one-cycle write / read strobes
//   reg_rdata                   read data, valid READ_LATENCY cycles after reg_re

module usb_uart_cmd #(
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 48000000
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata
);

  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StAddrHi,
    StAddrLo,
    StDataHi,
    StDataLo,
    StExec,
    StRdWait,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic            op_write_q, op_write_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic [1:0]      lat_cnt_q, lat_cnt_d;
  // Response bytes go out from index 0; the buffer shifts down per handshake.
  logic [2:0][7:0] resp_buf_q, resp_buf_d;
  logic [1:0]      resp_cnt_q, resp_cnt_d;

  logic       parse_st;    // state that accepts rx bytes
  logic       byte_acc;    // rx handshake this cycle
  logic       proc_valid;  // a byte is acted on by the parser this cycle
  logic [7:0] proc_byte;
  logic       echo_busy;   // an echo byte is occupying tx
  logic [7:0] echo_tx;
  logic [4:0] hex;         // {is_hex, nibble} of proc_byte
  logic       load_err;

  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = 5'b0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 gives 10..15
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

  function automatic logic [7:0] hex_encode(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : {4'h4, n - 4'd9};
  endfunction

  assign parse_st = (state_q == StIdle)   || (state_q == StAddrHi) || (state_q == StAddrLo) ||
                    (state_q == StDataHi) || (state_q == StDataLo);
  assign rx_ready = parse_st && !reset && !echo_busy;
  assign byte_acc = rx_valid && rx_ready;
  assign hex      = hex_decode(proc_byte);

`ifdef USB_UART_CMD_ECHO_EN
  logic       echo_pend_q, echo_pend_d;
  logic [7:0] echo_byte_q, echo_byte_d;

  // An accepted byte is parked here; it is parsed on the cycle its echo is taken.
  assign echo_busy  = echo_pend_q;
  assign echo_tx    = echo_byte_q;
  assign proc_valid = echo_pend_q && tx_ready;
  assign proc_byte  = echo_byte_q;

  always_comb begin
    echo_pend_d = echo_pend_q;
    echo_byte_d = echo_byte_q;
    if (proc_valid) begin
      echo_pend_d = 1'b0;
    end
    if (byte_acc) begin
      echo_pend_d = 1'b1;
      echo_byte_d = rx_data;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      echo_pend_q <= 1'b0;
      echo_byte_q <= 8'h00;
    end else begin
      echo_pend_q <= echo_pend_d;
      echo_byte_q <= echo_byte_d;
    end
  end
`else
  assign echo_busy  = 1'b0;
  assign echo_tx    = 8'h00;
  assign proc_valid = byte_acc;
  assign proc_byte  = rx_data;
`endif

  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    to_cnt_d   = to_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    resp_buf_d = resp_buf_q;
    resp_cnt_d = resp_cnt_q;
    load_err   = 1'b0;

    unique case (state_q)
      StIdle: begin
        to_cnt_d = '0;
        if (proc_valid) begin
          case (proc_byte)
            8'h72, 8'h52: begin
              op_write_d = 1'b0;
              state_d    = StAddrHi;
            end
            8'h77, 8'h57: begin
              op_write_d = 1'b1;
              state_d    = StAddrHi;
            end
            8'h0D, 8'h0A, 8'h20: ;
            default: load_err = 1'b1;
          endcase
        end
      end

      StAddrHi, StAddrLo, StDataHi, StDataLo: begin
        // A byte in the same cycle as expiry wins.
        if (byte_acc || echo_busy) begin
          to_cnt_d = '0;
        end else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
          to_cnt_d = '0;
          state_d  = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end

        if (proc_valid) begin
          if (!hex[4]) begin
            load_err = 1'b1;
          end else if (state_q == StAddrHi) begin
            addr_d  = {addr_q[3:0], hex[3:0]};
            state_d = StAddrLo;
          end else if (state_q == StAddrLo) begin
            addr_d  = {addr_q[3:0], hex[3:0]};
            state_d = op_write_q ? StDataHi : StExec;
          end else if (state_q == StDataHi) begin
            wdata_d = {wdata_q[3:0], hex[3:0]};
            state_d = StDataLo;
          end else begin
            wdata_d = {wdata_q[3:0], hex[3:0]};
            state_d = StExec;
          end
        end
      end

      StExec: begin
        to_cnt_d = '0;
        if (op_write_q) begin
          resp_buf_d = {8'h00, 8'h0A, 8'h6B};
          resp_cnt_d = 2'd2;
          state_d    = StResp;
        end else begin
          lat_cnt_d = 2'd0;
          state_d   = StRdWait;
        end
      end

      StRdWait: begin
        to_cnt_d = '0;
        if (lat_cnt_q == 2'(READ_LATENCY - 1)) begin
          resp_buf_d = {8'h0A, hex_encode(reg_rdata[3:0]), hex_encode(reg_rdata[7:4])};
          resp_cnt_d = 2'd3;
          state_d    = StResp;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end

      StResp: begin
        to_cnt_d = '0;
        if (tx_ready) begin
          resp_buf_d = {8'h00, resp_buf_q[2], resp_buf_q[1]};
          resp_cnt_d = resp_cnt_q - 2'd1;
          if (resp_cnt_q == 2'd1) begin
            state_d = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    if (load_err) begin
      resp_buf_d = {8'h00, 8'h0A, 8'h3F};
      resp_cnt_d = 2'd2;
      to_cnt_d   = '0;
      state_d    = StResp;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_q    <= StIdle;
      op_write_q <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      to_cnt_q   <= '0;
      lat_cnt_q  <= 2'd0;
      resp_buf_q <= '0;
      resp_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      to_cnt_q   <= to_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      resp_buf_q <= resp_buf_d;
      resp_cnt_q <= resp_cnt_d;
    end
  end

  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = (state_q == StExec) && op_write_q;
  assign reg_re    = (state_q == StExec) && !op_write_q;
  assign tx_valid  = (state_q == StResp) || echo_busy;
  assign tx_data   = echo_busy ? echo_tx :
                     (state_q == StResp) ? resp_buf_q[0] : 8'h00;

endmodule

// File: tb/tb_usb_uart_cmd.sv
// Bench for usb_uart_cmd (default build, READ_LATENCY=2, TIMEOUT_CYCLES=100).
// A string-level command model predicts tx bytes and bus strobes; a negedge
// monitor compares DUT activity against those queues every cycle.

module tb_usb_uart_cmd;

  localparam int unsigned RL = 2;
  localparam int unsigned TO = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  usb_uart_cmd #(
    .READ_LATENCY  (RL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_48mhz(clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- register slave: data only valid exactly RL cycles after reg_re
  logic [7:0]    slave_mem [256];
  logic [RL-1:0] re_pipe;
  logic [7:0]    re_addr;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) slave_mem[i] <= 8'h00;
      re_pipe <= '0;
      re_addr <= 8'h00;
    end else begin
      re_pipe <= (re_pipe << 1) | RL'(reg_re);
      if (reg_re) re_addr <= reg_addr;
      if (reg_we) slave_mem[reg_addr] <= reg_wdata;
    end
  end

  assign reg_rdata = re_pipe[RL-1] ? slave_mem[re_addr] : ~slave_mem[re_addr];

  // ---------------- command model
  logic [7:0]  model_mem [256];
  logic [7:0]  exp_tx[$];
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];

  function automatic bit is_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "a" && c <= "f") || (c >= "A" && c <= "F");
  endfunction

  function automatic int hex_val(input logic [7:0] c);
    if (c <= "9") return int'(c) - int'("0");
    if (c >= "a") return int'(c) - int'("a") + 10;
    return int'(c) - int'("A") + 10;
  endfunction

  function automatic logic [7:0] hex_chr(input int n);
    string digits;
    digits = "0123456789ABCDEF";
    return digits[n];
  endfunction

  task automatic push_err();
    exp_tx.push_back("?");
    exp_tx.push_back("\n");
  endtask

  // Predicts everything a command string produces, starting from idle.
  // A string that ends inside a command is assumed to time out silently.
  task automatic model_cmds(input string s);
    int i, j, nd, val;
    bit bad;
    logic [7:0] c;
    i = 0;
    while (i < s.len()) begin
      c = s[i];
      if (c == "\r" || c == "\n" || c == " ") begin
        i++;
      end else if (c == "r" || c == "R" || c == "w" || c == "W") begin
        nd  = (c == "w" || c == "W") ? 4 : 2;
        val = 0;
        bad = 1'b0;
        j   = 0;
        while (j < nd && i + 1 + j < s.len() && !bad) begin
          if (is_hex(s[i+1+j])) begin
            val = val * 16 + hex_val(s[i+1+j]);
            j++;
          end else begin
            bad = 1'b1;
          end
        end
        if (bad) begin
          push_err();
          i = i + 2 + j;
        end else if (j < nd) begin
          i = s.len();
        end else begin
          if (nd == 4) begin
            exp_wr.push_back(16'(val));
            model_mem[val / 256] = 8'(val % 256);
            exp_tx.push_back("k");
            exp_tx.push_back("\n");
          end else begin
            exp_rd.push_back(8'(val));
            exp_tx.push_back(hex_chr(int'(model_mem[val]) / 16));
            exp_tx.push_back(hex_chr(int'(model_mem[val]) % 16));
            exp_tx.push_back("\n");
          end
          i = i + 1 + nd;
        end
      end else begin
        push_err();
        i++;
      end
    end
  endtask

  // ---------------- monitor
  bit         prev_strobe, prev_stall, prev_txv;
  logic [7:0] prev_data;
  int         last_acc;
  int         rise_exp = -1;

  always @(negedge clk) begin
    if (reset) begin
      exp_tx.delete();
      rise_exp    = -1;
      prev_strobe = 1'b0;
      prev_stall  = 1'b0;
      prev_txv    = 1'b0;
    end else begin
      check("we_re_exclusive", 32'(reg_we && reg_re), 32'd0);
      if (prev_strobe) check("strobe_one_cycle", 32'(reg_we || reg_re), 32'd0);
      if (tx_valid) check("rx_blocked_during_tx", 32'(rx_ready), 32'd0);
      if (prev_stall) begin
        check("tx_valid_held", 32'(tx_valid), 32'd1);
        check("tx_data_held", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && !prev_txv && rise_exp >= 0) begin
        check("resp_latency", 32'(cyc), 32'(rise_exp));
        rise_exp = -1;
      end
      if (rx_valid && rx_ready) last_acc = cyc;
      if (reg_we) begin
        check("we_latency", 32'(cyc), 32'(last_acc + 1));
        if (exp_wr.size() == 0) begin
          check("unexpected_we_addr", 32'(reg_addr), 32'hFFFF_FFFF);
        end else begin
          logic [15:0] e;
          e = exp_wr.pop_front();
          check("wr_addr", 32'(reg_addr), 32'(e[15:8]));
          check("wr_data", 32'(reg_wdata), 32'(e[7:0]));
        end
        rise_exp = cyc + 1;
      end
      if (reg_re) begin
        check("re_latency", 32'(cyc), 32'(last_acc + 1));
        if (exp_rd.size() == 0) begin
          check("unexpected_re_addr", 32'(reg_addr), 32'hFFFF_FFFF);
        end else begin
          check("rd_addr", 32'(reg_addr), 32'(exp_rd.pop_front()));
        end
        rise_exp = cyc + 1 + int'(RL);
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) check("unexpected_tx_byte", 32'(tx_data), 32'hFFFF_FFFF);
        else check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
      prev_strobe = reg_we || reg_re;
      prev_stall  = tx_valid && !tx_ready;
      prev_data   = tx_data;
      prev_txv    = tx_valid;
    end
  end

  // ---------------- drivers (called #1 after a posedge)
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      t++;
      if (t > 300) begin
        check("rx_ready_timeout", 32'(rx_ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_tx.size() + exp_wr.size() + exp_rd.size()) != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check({"drain_", name}, 32'(exp_tx.size() + exp_wr.size() + exp_rd.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run(input string s);
    model_cmds(s);
    send_str(s);
    drain(s);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_reg_addr"}, 32'(reg_addr), 32'd0);
    check({tag, "_reg_wdata"}, 32'(reg_wdata), 32'd0);
    check({tag, "_reg_we"}, 32'(reg_we), 32'd0);
    check({tag, "_reg_re"}, 32'(reg_re), 32'd0);
  endtask

  task automatic clear_model_mem();
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish by 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    reset    = 1'b1;
    clear_model_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Write: model pinned against literals first.
    model_cmds("w3Ca5");
    check("model_w_tx", {exp_tx[0], exp_tx[1]}, 32'h6B0A);
    check("model_w_bus", 32'(exp_wr[0]), 32'h3CA5);
    send_str("w3Ca5");
    drain("w3Ca5");
    check("slave_3c_written", 32'(slave_mem[8'h3C]), 32'hA5);

    // Read of 0x7E.
    run("w3C7E");
    model_cmds("R3c");
    check("model_r_tx", {exp_tx[0], exp_tx[1], exp_tx[2]}, 32'h37450A);
    send_str("R3c");
    drain("R3c");
    check("addr_held_after_read", 32'(reg_addr), 32'h3C);

    // Error and ignored bytes.
    run("x");
    run("r3g");
    run("\r\n ");
    run("WffFF");
    run("rFF");
    run(" w12C3\nr12\r");

    // Timeout abort, then a normal read.
    model_cmds("w1");
    send_str("w1");
    repeat (TO + 5) @(posedge clk);
    #1;
    run("r00");

    // A gap just short of the timeout keeps the command alive.
    model_cmds("r12");
    send_byte("r");
    repeat (TO - 3) @(posedge clk);
    #1;
    send_str("12");
    drain("r12_slow");

    // Back-pressure on the response.
    tx_ready = 1'b0;
    model_cmds("R3c");
    send_str("R3c");
    t = 0;
    while (!tx_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("stall_tx_valid_seen", 32'(tx_valid), 32'd1);
    repeat (10) begin
      @(negedge clk);
      check("stall_tx_valid", 32'(tx_valid), 32'd1);
      check("stall_tx_data", 32'(tx_data), 32'h37);
      check("stall_rx_ready", 32'(rx_ready), 32'd0);
    end
    @(posedge clk);
    #1 tx_ready = 1'b1;
    drain("R3c_stall");

    // Reset while waiting for read data.
    model_cmds("r3c");
    send_str("r3c");
    @(posedge clk);
    #1 reset = 1'b1;
    clear_model_mem();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_read_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    run("w0001");
    check("slave_00_written", 32'(slave_mem[8'h00]), 32'h01);

    repeat (20) @(posedge clk);
    check("final_queues_empty", 32'(exp_tx.size() + exp_wr.size() + exp_rd.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_uart_cmd.md
Name: usb_uart_cmd

Overview:
- ASCII command/register bridge; sits directly downstream of the USB serial wrapper's `uart_out` pipe and directly upstream of its `uart_in` pipe.
- Parses short hex commands sent by the host and performs single-byte register reads/writes on a simple internal bus.
- Returns an ASCII response to the host for every completed or rejected command.
- Gives bring-up and debug access to fabric registers over the USB serial link.

Parameters:
- READ_LATENCY, 1, cycles from reg_re pulse to reg_rdata valid (legal 1..4)
- TIMEOUT_CYCLES, 48000000, idle cycles inside a partial command before silent abort (1 s at 48 MHz; minimum 2)

Ports:
- clk_48mhz  input  1  sole clock
- reset  input  1  synchronous, active-high reset
- rx_data  input  8  host-to-device byte; connects to uart_out_data
- rx_valid  input  1  rx byte valid; connects to uart_out_valid
- rx_ready  output  1  byte accepted when rx_valid && rx_ready; connects to uart_out_ready
- tx_data  output  8  device-to-host byte; connects to uart_in_data
- tx_valid  output  1  tx byte valid; connects to uart_in_valid
- tx_ready  input  1  tx byte taken when tx_valid && tx_ready; connects to uart_in_ready
- reg_addr  output  8  register address, held from the address parse until the next command
- reg_wdata  output  8  write data
- reg_we  output  1  one-cycle write strobe
- reg_re  output  1  one-cycle read strobe
- reg_rdata  input  8  read data, sampled READ_LATENCY cycles after reg_re

Behaviour:
- Reset values: rx_ready=0, tx_valid=0, tx_data=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0; state IDLE; timeout counter 0.
- Reset mid-command or mid-response discards all progress; nothing is sent afterwards.
- Command grammar:
  - `r`/`R` followed by two hex digits: read.
  - `w`/`W` followed by four hex digits (address, then data): write.
  - Hex digits are 0-9, a-f, A-F.
- States: IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, EXEC, RD_WAIT, RESP.
- rx_ready=1 only in IDLE, ADDR_HI, ADDR_LO, DATA_HI and DATA_LO. At most one byte is consumed per cycle.
- IDLE transitions:
  - r/R -> ADDR_HI with op=read.
  - w/W -> ADDR_HI with op=write.
  - CR, LF or space: ignored, no response.
  - Any other byte -> RESP with "?\n".
- Hex-digit states:
  - Each valid digit shifts into reg_addr (high nibble first) or reg_wdata, then advances to the next state.
  - ADDR_LO goes to EXEC for a read, DATA_HI for a write.
  - DATA_LO goes to EXEC.
  - A non-hex byte goes to RESP with "?\n"; no bus strobe is issued.
- EXEC:
  - Lasts exactly one cycle.
  - Write: reg_we=1, then RESP with "k\n".
  - Read: reg_re=1, then RD_WAIT.
- RD_WAIT:
  - Counts READ_LATENCY cycles after the reg_re pulse, then captures reg_rdata.
  - Goes to RESP with three bytes: uppercase hex high nibble, uppercase hex low nibble, "\n".
- RESP:
  - Response bytes come from a 3-entry buffer with a byte count.
  - tx_valid=1 with tx_data stable until tx_ready.
  - Advances one byte per handshake; goes to IDLE the cycle after the last handshake.
  - No rx bytes are consumed during RESP.
- Timeout:
  - Counter clears on every accepted byte and in IDLE.
  - In ADDR_HI..DATA_LO it increments each cycle without an accepted byte.
  - Reaching TIMEOUT_CYCLES-1 forces IDLE: no strobe, no response.
  - Same-cycle byte and timeout: the byte wins and the counter clears.
- Latency: final command byte accepted at cycle N -> strobe at N+1.
  - Write: first tx_valid at N+2.
  - Read: first tx_valid at N+2+READ_LATENCY.
- reg_we and reg_re are never high together, and never high for more than one cycle.

Optional Feature:
- Macro: USB_UART_CMD_ECHO_EN.
- Defined:
  - Every byte accepted in IDLE..DATA_LO is echoed to tx before parsing continues.
  - rx_ready is additionally gated low while an echo is pending.
  - The echo completes (tx handshake) before that byte's state transition takes effect.
  - The response follows after all echoes.
- Undefined: no echo; tx carries only responses.

Test Plan:
- Send "w3Ca5" -> one-cycle reg_we with reg_addr=0x3C, reg_wdata=0xA5; tx bytes 'k', '\n'; reg_re never asserted.
- Send "R3c" with reg_rdata=0x7E at READ_LATENCY -> one-cycle reg_re with reg_addr=0x3C; tx bytes '7', 'E', '\n'.
- Send "x" -> tx '?', '\n'. Then send "r3g" -> tx '?', '\n' with no reg_re. Then "\r\n " alone -> no tx output.
- Send "w1" then idle for TIMEOUT_CYCLES (TIMEOUT_CYCLES=100 build) -> no strobe, no tx. Then "r00" with reg_rdata=0x00 -> tx '0', '0', '\n'.
- Read response with tx_ready held low for 10 cycles -> tx_valid stays 1, tx_data stays '7', rx_ready stays 0. Release -> remaining bytes delivered in order.
- Assert reset during RD_WAIT -> all outputs return to reset values on the next edge; no tx bytes. A following "w0001" behaves normally.
